// File: rtl/rails_pkg.sv
// Shared constants and types for the rails station scheduler.
package rails_pkg;
    localparam int MAX_N       = 15;
    localparam int CW          = 4;
    localparam int STACK_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } rails_state_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;
endpackage

// File: rtl/rails_station_stack.sv
// 16-entry LIFO siding; push and pop are never requested in the same cycle.
module rails_station_stack
    import rails_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [CW-1:0] din,
    output logic [CW-1:0] top,
    output logic          empty,
    output logic          full
);
    localparam int PW = $clog2(STACK_DEPTH) + 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-2:0] top_idx_s;
    logic [CW-1:0] mem_q [STACK_DEPTH];
    logic          do_push_s, do_pop_s;

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign top_idx_s = ptr_q[PW-2:0] - (PW-1)'(1);
    assign top       = mem_q[top_idx_s];
    assign empty     = (ptr_q == {PW{1'b0}});
    assign full      = (ptr_q == PW'(STACK_DEPTH));

    always_comb begin
        ptr_d = ptr_q;
        if (do_push_s) begin
            ptr_d = ptr_q + PW'(1);
        end else if (do_pop_s) begin
            ptr_d = ptr_q - PW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= {PW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage needs no reset: only entries below the pointer are ever read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[ptr_q[PW-2:0]] <= din;
        end
    end
endmodule

// File: rtl/rails_sched.sv
// Rails scheduler: loads a departure order, then greedily sequences pushes/pops
// on the station stack and reports whether the order is achievable.
module rails_sched #(
    parameter int MAX_N = 15,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] number,
    input  logic [CW-1:0] data,
    output logic          op_valid,
    output logic          op_push,
    output logic [CW-1:0] op_coach,
    output logic          valid,
    output logic          result,
    output logic          busy
);
    import rails_pkg::*;

    rails_state_t  state_q, state_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW:0]   next_in_q, next_in_d;
    logic [CW-1:0] target_q [MAX_N+1];
    logic [CW-1:0] target_d [MAX_N+1];
    logic          op_valid_q, op_valid_d;
    logic          op_push_q, op_push_d;
    logic [CW-1:0] op_coach_q, op_coach_d;
    logic          valid_q, valid_d;
    logic          result_q, result_d;
    logic          busy_q, busy_d;
    logic          stk_push_s, stk_pop_s, stk_reset_s, stk_empty_s, stk_full_s;
    logic [CW-1:0] stk_top_s, tgt_s;

    // Leftover coaches from a failed order are discarded while DONE is shown.
    assign stk_reset_s = reset || (state_q == DONE);
    assign tgt_s       = target_q[idx_q];

    rails_station_stack u_stack (
        .clk   (clk),
        .reset (stk_reset_s),
        .push  (stk_push_s),
        .pop   (stk_pop_s),
        .din   (next_in_q[CW-1:0]),
        .top   (stk_top_s),
        .empty (stk_empty_s),
        .full  (stk_full_s)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        next_in_d  = next_in_q;
        target_d   = target_q;
        op_valid_d = 1'b0;
        op_push_d  = 1'b0;
        op_coach_d = {CW{1'b0}};
        valid_d    = 1'b0;
        result_d   = 1'b0;
        busy_d     = busy_q;
        stk_push_s = 1'b0;
        stk_pop_s  = 1'b0;
        case (state_q)
            IDLE: begin
                n_d       = number;
                idx_d     = {CW{1'b0}};
                next_in_d = (CW+1)'(1);
                busy_d    = 1'b1;
                if (number == {CW{1'b0}}) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    result_d = 1'b1;
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                target_d[idx_q] = data;
                if (idx_q == n_q - CW'(1)) begin
                    idx_d   = {CW{1'b0}};
                    state_d = RUN;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            RUN: begin
                if (idx_q == n_q) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    result_d = 1'b1;
                end else if (!stk_empty_s && (stk_top_s == tgt_s)) begin
                    stk_pop_s  = 1'b1;
                    op_valid_d = 1'b1;
                    op_push_d  = OP_POP;
                    op_coach_d = stk_top_s;
                    idx_d      = idx_q + CW'(1);
                end else if ((next_in_q <= {1'b0, n_q}) && (next_in_q <= {1'b0, tgt_s})
                             && !stk_full_s) begin
                    stk_push_s = 1'b1;
                    op_valid_d = 1'b1;
                    op_push_d  = OP_PUSH;
                    op_coach_d = next_in_q[CW-1:0];
                    next_in_d  = next_in_q + (CW+1)'(1);
                end else begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    result_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            n_q        <= {CW{1'b0}};
            idx_q      <= {CW{1'b0}};
            next_in_q  <= (CW+1)'(1);
            op_valid_q <= 1'b0;
            op_push_q  <= 1'b0;
            op_coach_q <= {CW{1'b0}};
            valid_q    <= 1'b0;
            result_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            next_in_q  <= next_in_d;
            op_valid_q <= op_valid_d;
            op_push_q  <= op_push_d;
            op_coach_q <= op_coach_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
        end
    end

    // Target buffer is pure data; its contents only matter after LOAD rewrites them.
    always_ff @(posedge clk) begin
        target_q <= target_d;
    end

    assign op_valid = op_valid_q;
    assign op_push  = op_push_q;
    assign op_coach = op_coach_q;
    assign valid    = valid_q;
    assign result   = result_q;
    assign busy     = busy_q;
endmodule
